// File: rtl/divisor_pkg.sv
// Shared definitions for the keypad-to-divider sequencing controller.
// Provides the controller state encoding, the nibble shown on every
// display digit while in the error state, default sizing, and a helper
// that turns an operand width into a hex digit count.
package divisor_pkg;

    // Controller states, from operand entry through result display.
    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        START,
        WAIT,
        SHOW,
        ERR
    } state_t;

    localparam logic [3:0] ERR_NIBBLE      = 4'hE;
    localparam int         DEFAULT_WIDTH   = 8;
    localparam int         DEFAULT_TIMEOUT = 64;

    // Number of hex digits needed to fill an operand of the given width.
    function automatic int digit_count(input int width);
        return width / 4;
    endfunction

endpackage

// File: rtl/hex_shift_entry.sv
// Operand entry register: shifts hex digits in from the right, most
// significant digit first, and tracks how many digits have been entered.
//
// Ports:
//   clk          - system clock
//   rst          - asynchronous active-high reset, clears value and count
//   clear_i      - clear value and digit count
//   load_first_i - clear, then load key_i as the first digit (count = 1)
//   shift_i      - shift value left one nibble and insert key_i
//   key_i        - hex digit to insert
//   value_o      - current registered operand
//   next_o       - operand value after this cycle's update
//   last_o       - the next shift completes the operand
module hex_shift_entry
    import divisor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             load_first_i,
    input  logic             shift_i,
    input  logic [3:0]       key_i,
    output logic [WIDTH-1:0] value_o,
    output logic [WIDTH-1:0] next_o,
    output logic             last_o
);

    localparam int DIGITS = digit_count(WIDTH);
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [WIDTH-1:0] value_q, value_d;
    logic [CW-1:0]    count_q, count_d;

    // The digit counter wraps to zero on the completing digit, so a full
    // operand leaves the counter ready for the next entry.
    always_comb begin
        value_d = value_q;
        count_d = count_q;
        if (clear_i) begin
            value_d = '0;
            count_d = '0;
        end else if (load_first_i) begin
            value_d = WIDTH'(key_i);
            count_d = CW'(1 % DIGITS);
        end else if (shift_i) begin
            value_d = (value_q << 4) | WIDTH'(key_i);
            if (count_q == CW'(DIGITS - 1)) begin
                count_d = '0;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            count_q <= '0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

    assign value_o = value_q;
    assign next_o  = value_d;
    assign last_o  = (count_q == CW'(DIGITS - 1));

endmodule

// File: rtl/divisor_ctrl.sv
// Sequencing controller between the keypad decoder and the integer divider.
// Collects dividend A and divisor B as hex digits, launches the divider,
// waits for completion under a timeout, and feeds the 7-segment mux with
// entry digits, quotient/remainder, or an all-E error pattern.
//
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   key_valid  - one-cycle pulse per debounced key press
//   key_code   - hex value of the pressed key
//   div_start  - one-cycle divider launch pulse
//   div_a      - dividend (mirrors the A entry register)
//   div_b      - divisor (mirrors the B entry register)
//   div_done   - one-cycle divider completion pulse
//   div_q      - quotient, valid with div_done
//   div_r      - remainder, valid with div_done
//   disp_value - display value, upper half on the left digits
//   busy       - high while launching and waiting on the divider
//   err        - high in the error state
module divisor_ctrl
    import divisor_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [3:0]         key_code,
    output logic               div_start,
    output logic [WIDTH-1:0]   div_a,
    output logic [WIDTH-1:0]   div_b,
    input  logic               div_done,
    input  logic [WIDTH-1:0]   div_q,
    input  logic [WIDTH-1:0]   div_r,
    output logic [2*WIDTH-1:0] disp_value,
    output logic               busy,
    output logic               err
);

    localparam int DIGITS  = digit_count(WIDTH);
    localparam int NIBBLES = (2 * WIDTH) / 4;
    localparam int TW      = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [TW-1:0]      timeout_q, timeout_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic               div_start_q, div_start_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [2*WIDTH-1:0] disp_q, disp_d;

    logic               a_load, a_shift, a_last;
    logic               b_clear, b_shift, b_last;
    logic [WIDTH-1:0]   a_val, a_next, b_val, b_next;

    hex_shift_entry #(.WIDTH(WIDTH)) u_entry_a (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (1'b0),
        .load_first_i (a_load),
        .shift_i      (a_shift),
        .key_i        (key_code),
        .value_o      (a_val),
        .next_o       (a_next),
        .last_o       (a_last)
    );

    hex_shift_entry #(.WIDTH(WIDTH)) u_entry_b (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (b_clear),
        .load_first_i (1'b0),
        .shift_i      (b_shift),
        .key_i        (key_code),
        .value_o      (b_val),
        .next_o       (b_next),
        .last_o       (b_last)
    );

    // Next-state logic. Keys are only honoured in the entry states and as
    // the re-entry key from SHOW/ERR; div_done is only honoured in WAIT.
    // The timeout compares the incremented count so the error state is
    // entered exactly TIMEOUT cycles after the launch pulse, and a
    // same-cycle div_done takes priority over the timeout.
    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        result_d  = result_q;
        a_load    = 1'b0;
        a_shift   = 1'b0;
        b_clear   = 1'b0;
        b_shift   = 1'b0;
        case (state_q)
            ENTER_A: begin
                if (key_valid) begin
                    a_shift = 1'b1;
                    if (a_last) begin
                        state_d = ENTER_B;
                    end
                end
            end
            ENTER_B: begin
                if (key_valid) begin
                    b_shift = 1'b1;
                    if (b_last) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                timeout_d = '0;
                state_d   = (b_val == '0) ? ERR : WAIT;
            end
            WAIT: begin
                timeout_d = timeout_q + TW'(1);
                if (div_done) begin
                    result_d = {div_q, div_r};
                    state_d  = SHOW;
                end else if (timeout_d == TW'(TIMEOUT - 1)) begin
                    state_d = ERR;
                end
            end
            SHOW, ERR: begin
                if (key_valid) begin
                    a_load  = 1'b1;
                    b_clear = 1'b1;
                    state_d = (DIGITS == 1) ? ENTER_B : ENTER_A;
                end
            end
            default: begin
                state_d = ENTER_A;
            end
        endcase
    end

    // Outputs are computed from the next state and next register values,
    // then registered, so they line up with the state they describe.
    always_comb begin
        busy_d      = (state_d == START) || (state_d == WAIT);
        err_d       = (state_d == ERR);
        div_start_d = (state_d == START) && (b_next != '0);
        case (state_d)
            SHOW:    disp_d = result_d;
            ERR:     disp_d = {NIBBLES{ERR_NIBBLE}};
            default: disp_d = {a_next, b_next};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ENTER_A;
            timeout_q   <= '0;
            result_q    <= '0;
            div_start_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            disp_q      <= '0;
        end else begin
            state_q     <= state_d;
            timeout_q   <= timeout_d;
            result_q    <= result_d;
            div_start_q <= div_start_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            disp_q      <= disp_d;
        end
    end

    assign div_start  = div_start_q;
    assign div_a      = a_val;
    assign div_b      = b_val;
    assign busy       = busy_q;
    assign err        = err_q;
    assign disp_value = disp_q;

endmodule

// File: tb/tb_divisor_ctrl.sv
// Self-checking bench for divisor_ctrl. Operations are described by their
// four key digits; expected displays, quotients and error outcomes are
// computed from those digits with plain arithmetic. A small divider
// stand-in answers div_start after a programmable latency.
module tb_divisor_ctrl;

    localparam int W  = 8;
    localparam int TO = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         key_valid;
    logic [3:0]   key_code;
    logic         div_start;
    logic [W-1:0] div_a, div_b;
    logic         div_done;
    logic [W-1:0] div_q, div_r;
    logic [2*W-1:0] disp_value;
    logic         busy, err;

    int checksDone   = 0;
    int checksPassed = 0;
    int cycle        = 0;

    // Divider stand-in state
    bit           divRespond  = 1'b1;
    int           divLatency  = 1;
    int           divCountdown = -1;
    logic [W-1:0] pendQ, pendR;
    int           startCount  = 0;

    divisor_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .div_start  (div_start),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_done   (div_done),
        .div_q      (div_q),
        .div_r      (div_r),
        .disp_value (disp_value),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksDone++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // Advance to the next falling edge, drop one-shot inputs and run the
    // divider stand-in.
    task automatic stepCycle();
        @(negedge clk);
        cycle++;
        key_valid = 1'b0;
        div_done  = 1'b0;
        div_q     = W'($urandom);
        div_r     = W'($urandom);
        if (divCountdown > 0) begin
            divCountdown--;
            if (divCountdown == 0) begin
                div_done     = 1'b1;
                div_q        = pendQ;
                div_r        = pendR;
                divCountdown = -1;
            end
        end
        if (div_start) begin
            startCount++;
            if (divRespond) begin
                divCountdown = divLatency;
                if (div_b != '0) begin
                    pendQ = div_a / div_b;
                    pendR = div_a % div_b;
                end else begin
                    pendQ = '0;
                    pendR = '0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [3:0] k);
        stepCycle();
        key_valid = 1'b1;
        key_code  = k;
    endtask

    // One complete operation: four keys, launch, wait, result.
    task automatic doOperation(input logic [15:0] keys, input bit respond, input int latency,
                               input bit injectKey, input int resetAt);
        logic [3:0] d[4];
        int a, b, expA, expB, expDisp, startsBefore, startPeriod, endPeriod;
        bit finished, expectErr;
        for (int i = 0; i < 4; i++) d[i] = keys[15-4*i -: 4];
        a = d[0] * 16 + d[1];
        b = d[2] * 16 + d[3];
        divRespond   = respond;
        divLatency   = latency;
        startsBefore = startCount;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(d[i]);
            stepCycle();
            expA = (i >= 1) ? a : d[0];
            expB = (i == 2) ? d[2] : ((i == 3) ? b : 0);
            checkOutput("entry disp", 32'(disp_value), 32'(expA * 256 + expB));
            if (i < 3) begin
                checkOutput("entry busy", 32'(busy), 32'(0));
                checkOutput("entry err", 32'(err), 32'(0));
            end
        end
        startPeriod = cycle;
        checkOutput("start pulse", 32'(div_start), 32'(b != 0));
        checkOutput("start busy", 32'(busy), 32'(1));
        checkOutput("operand a", 32'(div_a), 32'(a));
        checkOutput("operand b", 32'(div_b), 32'(b));
        finished  = 1'b0;
        endPeriod = -1;
        for (int k = 1; k <= TO + 8 && !finished; k++) begin
            stepCycle();
            if (k == resetAt) begin
                #1 rst = 1'b1;
                #1;
                checkOutput("reset div_start", 32'(div_start), 32'(0));
                checkOutput("reset busy", 32'(busy), 32'(0));
                checkOutput("reset err", 32'(err), 32'(0));
                checkOutput("reset disp", 32'(disp_value), 32'(0));
                checkOutput("reset div_a", 32'(div_a), 32'(0));
                checkOutput("reset div_b", 32'(div_b), 32'(0));
                #2 rst = 1'b0;
                for (int j = 0; j < 15; j++) stepCycle();
                checkOutput("post-reset disp", 32'(disp_value), 32'(0));
                checkOutput("post-reset busy", 32'(busy), 32'(0));
                checkOutput("post-reset err", 32'(err), 32'(0));
                checkOutput("post-reset starts", 32'(startCount - startsBefore), 32'(1));
                return;
            end
            if (err || !busy) begin
                finished  = 1'b1;
                endPeriod = cycle;
            end else begin
                checkOutput("hold a", 32'(div_a), 32'(a));
                checkOutput("hold b", 32'(div_b), 32'(b));
                checkOutput("single start", 32'(div_start), 32'(0));
                if (injectKey && k == 2) begin
                    key_valid = 1'b1;
                    key_code  = 4'h9;
                end
            end
        end
        checkOutput("bounded wait", 32'(finished), 32'(1));
        expectErr = (b == 0) || !respond || (latency >= TO);
        expDisp   = expectErr ? 32'hEEEE : (((a / b) << 8) | (a % b));
        checkOutput("result disp", 32'(disp_value), 32'(expDisp));
        checkOutput("result err", 32'(err), 32'(expectErr));
        checkOutput("result busy", 32'(busy), 32'(0));
        checkOutput("start count", 32'(startCount - startsBefore), 32'(b != 0));
        if (b == 0) begin
            checkOutput("divzero latency", 32'(endPeriod - startPeriod), 32'(1));
        end else if (expectErr) begin
            checkOutput("timeout latency", 32'(endPeriod - startPeriod), 32'(TO));
        end else begin
            checkOutput("done latency", 32'(endPeriod - startPeriod), 32'(latency + 1));
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] keys;
        bit respond, inject;
        int latency;
        key_valid = 1'b0;
        key_code  = 4'h0;
        div_done  = 1'b0;
        div_q     = '0;
        div_r     = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst disp", 32'(disp_value), 32'(0));
        checkOutput("rst div_a", 32'(div_a), 32'(0));
        checkOutput("rst div_b", 32'(div_b), 32'(0));
        checkOutput("rst busy", 32'(busy), 32'(0));
        checkOutput("rst err", 32'(err), 32'(0));
        checkOutput("rst div_start", 32'(div_start), 32'(0));
        rst = 1'b0;

        $display("[TB] normal divide");
        doOperation(16'h7F50, 1'b1, 3, 1'b0, -1);
        $display("[TB] divide by zero, then re-entry");
        doOperation(16'h1200, 1'b1, 3, 1'b0, -1);
        doOperation(16'h3105, 1'b1, 5, 1'b0, -1);
        $display("[TB] timeout and late done");
        doOperation(16'h0802, 1'b0, 1, 1'b0, -1);
        stepCycle();
        div_done = 1'b1;
        div_q    = 8'h04;
        div_r    = 8'h00;
        stepCycle();
        stepCycle();
        checkOutput("late done disp", 32'(disp_value), 32'hEEEE);
        checkOutput("late done err", 32'(err), 32'(1));
        $display("[TB] key during wait");
        doOperation(16'h0802, 1'b1, 6, 1'b1, -1);
        $display("[TB] reset during wait");
        doOperation(16'h0802, 1'b1, 8, 1'b0, 3);
        $display("[TB] re-entry from show");
        doOperation(16'h7F50, 1'b1, 2, 1'b0, -1);
        doOperation(16'hFF0F, 1'b1, 4, 1'b0, -1);
        $display("[TB] done on the timeout boundary");
        doOperation(16'hC803, 1'b1, TO - 1, 1'b0, -1);
        doOperation(16'hC803, 1'b1, TO, 1'b0, -1);
        doOperation(16'h0101, 1'b1, 1, 1'b0, -1);

        $display("[TB] randomized operations");
        for (int n = 0; n < 40; n++) begin
            keys = 16'($urandom);
            if ($urandom_range(3) == 0) keys[7:0] = 8'h00;
            respond = ($urandom_range(9) != 0);
            latency = $urandom_range(TO + 2, 1);
            inject  = ($urandom_range(1) == 1) && (!respond || latency >= 3);
            doOperation(keys, respond, latency, inject, -1);
        end

        $display("%0d/%0d checks passed", checksPassed, checksDone);
        $finish;
    end

endmodule
